// File: rtl/reg_file_pkg.sv
// Shared constants and state type for the multi-port integer register file.
package reg_file_pkg;

    localparam int unsigned XLEN_DEF     = 64;
    localparam int unsigned NUM_REGS_DEF = 32;
    localparam int unsigned ZERO_REG     = 0;

    typedef enum logic [0:0] {
        RF_INIT,
        RF_READY
    } rf_state_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/write-back facing bus of the register file: reads, two retire lanes, issue, ready.
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_READ = 2
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    logic [NUM_READ*AW-1:0]   rd_addr;
    logic [NUM_READ*XLEN-1:0] rd_data;
    logic [NUM_READ-1:0]      rd_busy;
    logic                     wb0_en;
    logic [AW-1:0]            wb0_addr;
    logic [XLEN-1:0]          wb0_data;
    logic                     wb1_en;
    logic [AW-1:0]            wb1_addr;
    logic [XLEN-1:0]          wb1_data;
    logic                     issue_en;
    logic [AW-1:0]            issue_addr;
    logic                     ready;

    modport master (
        output rd_addr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
               issue_en, issue_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_addr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
               issue_en, issue_addr,
        output rd_data, rd_busy, ready
    );

endinterface

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits: issue sets, write-back clears, set beats clear; x0 is never busy.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_READ = 2,
    parameter int unsigned AW       = $clog2(NUM_REGS)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   set_en,
    input  logic [AW-1:0]          set_addr,
    input  logic                   clr0_en,
    input  logic [AW-1:0]          clr0_addr,
    input  logic                   clr1_en,
    input  logic [AW-1:0]          clr1_addr,
    input  logic [NUM_READ*AW-1:0] rd_addr,
    output logic [NUM_READ-1:0]    rd_busy
);

    logic [NUM_REGS-1:0] busy_q, busy_d;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (enable) begin
            if (clr0_en) busy_d[clr0_addr] = 1'b0;
            if (clr1_en) busy_d[clr1_addr] = 1'b0;
            // A same-cycle issue means a newer producer is in flight
            if (set_en)  busy_d[set_addr]  = 1'b1;
        end
        busy_d[ZERO_REG] = 1'b0;
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_lookup
        assign rd_busy[k] = enable & busy_q[rd_addr[k*AW +: AW]];
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with init sweep and busy scoreboard.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned NUM_READ = 2
) (
    input  logic         clock,
    input  logic         reset_n,
    reg_file_mp_if.slave bus
);

    localparam int unsigned AW = $clog2(NUM_REGS);

    rf_state_t       state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            ready;
    logic            wb0_we, wb1_we;
    logic [XLEN-1:0] mem [NUM_REGS];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RF_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RF_INIT: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NUM_REGS - 1)) state_d = RF_READY;
            end
            RF_READY: state_d = RF_READY;
        endcase
    end

    assign ready     = (state_q == RF_READY);
    assign bus.ready = ready;
    assign wb0_we    = ready && bus.wb0_en && (bus.wb0_addr != AW'(ZERO_REG));
    assign wb1_we    = ready && bus.wb1_en && (bus.wb1_addr != AW'(ZERO_REG));

    // Storage has no reset; the sweep zeroes it. wb1 is written last so it wins a collision.
    always_ff @(posedge clock) begin
        if (!ready) begin
            mem[cnt_q] <= '0;
        end else begin
            if (wb0_we) mem[bus.wb0_addr] <= bus.wb0_data;
            if (wb1_we) mem[bus.wb1_addr] <= bus.wb1_data;
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = bus.rd_addr[k*AW +: AW];

        always_comb begin
            data = mem[addr];
`ifdef REG_FILE_BYPASS_EN
            if (wb0_we && (bus.wb0_addr == addr)) data = bus.wb0_data;
            if (wb1_we && (bus.wb1_addr == addr)) data = bus.wb1_data;
`endif
            if (!ready || (addr == AW'(ZERO_REG))) data = '0;
        end

        assign bus.rd_data[k*XLEN +: XLEN] = data;
    end

    reg_file_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_READ (NUM_READ),
        .AW       (AW)
    ) u_scoreboard (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (ready),
        .set_en    (bus.issue_en),
        .set_addr  (bus.issue_addr),
        .clr0_en   (bus.wb0_en),
        .clr0_addr (bus.wb0_addr),
        .clr1_en   (bus.wb1_en),
        .clr1_addr (bus.wb1_addr),
        .rd_addr   (bus.rd_addr),
        .rd_busy   (bus.rd_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized bench for reg_file_mp against an array-based model, plus directed spot checks.
module tb_reg_file_mp;
    import reg_file_pkg::*;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned NUM_REGS  = 32;
    localparam int unsigned NUM_READ  = 2;
    localparam int unsigned AW        = 5;
    localparam int unsigned XLEN2     = 32;
    localparam int unsigned NUM_REGS2 = 16;
    localparam int unsigned NUM_READ2 = 4;
    localparam int unsigned AW2       = 4;

    logic clock = 1'b0;
    logic reset_n;
    bit   chk_on = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clock = ~clock;

    reg_file_mp_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_READ(NUM_READ)) bus ();
    reg_file_mp_if #(.XLEN(XLEN2), .NUM_REGS(NUM_REGS2), .NUM_READ(NUM_READ2)) bus2 ();

    reg_file_mp #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_READ(NUM_READ)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    reg_file_mp #(.XLEN(XLEN2), .NUM_REGS(NUM_REGS2), .NUM_READ(NUM_READ2)) dut2 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural contents and busy flags, ready after NUM_REGS clocks
    logic [XLEN-1:0] m_mem [NUM_REGS];
    bit              m_busy [NUM_REGS];
    bit              m_ready;
    int              m_clocks;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_ready  <= 1'b0;
            m_clocks <= 0;
            for (int i = 0; i < NUM_REGS; i++) m_busy[i] <= 1'b0;
        end else if (!m_ready) begin
            m_clocks <= m_clocks + 1;
            if (m_clocks + 1 == NUM_REGS) begin
                m_ready <= 1'b1;
                for (int i = 0; i < NUM_REGS; i++) m_mem[i] <= '0;
            end
        end else begin
            if (bus.wb0_en && bus.wb0_addr != 0) m_mem[bus.wb0_addr] <= bus.wb0_data;
            if (bus.wb1_en && bus.wb1_addr != 0) m_mem[bus.wb1_addr] <= bus.wb1_data;
            if (bus.wb0_en) m_busy[bus.wb0_addr] <= 1'b0;
            if (bus.wb1_en) m_busy[bus.wb1_addr] <= 1'b0;
            if (bus.issue_en && bus.issue_addr != 0) m_busy[bus.issue_addr] <= 1'b1;
        end
    end

    function automatic logic [XLEN-1:0] exp_data(int k);
        logic [AW-1:0]   a = bus.rd_addr[k*AW +: AW];
        logic [XLEN-1:0] v;
        if (!m_ready || a == 0) return '0;
        v = m_mem[a];
`ifdef REG_FILE_BYPASS_EN
        if (bus.wb0_en && bus.wb0_addr == a) v = bus.wb0_data;
        if (bus.wb1_en && bus.wb1_addr == a) v = bus.wb1_data;
`endif
        return v;
    endfunction

    function automatic bit exp_busy(int k);
        logic [AW-1:0] a = bus.rd_addr[k*AW +: AW];
        return m_ready ? m_busy[a] : 1'b0;
    endfunction

    // Compare process: inputs change on the falling edge, outputs settle 2 time units later
    always @(negedge clock) begin
        #2;
        if (chk_on) begin
            chk("ready", 64'(bus.ready), 64'(m_ready));
            for (int k = 0; k < NUM_READ; k++) begin
                chk("rd_data", 64'(bus.rd_data[k*XLEN +: XLEN]), 64'(exp_data(k)));
                chk("rd_busy", 64'(bus.rd_busy[k]), 64'(exp_busy(k)));
            end
        end
    end

    task automatic idle();
        bus.wb0_en = 1'b0; bus.wb0_addr = '0; bus.wb0_data = '0;
        bus.wb1_en = 1'b0; bus.wb1_addr = '0; bus.wb1_data = '0;
        bus.issue_en = 1'b0; bus.issue_addr = '0;
        bus.rd_addr = '0;
    endtask

    task automatic idle2();
        bus2.wb0_en = 1'b0; bus2.wb0_addr = '0; bus2.wb0_data = '0;
        bus2.wb1_en = 1'b0; bus2.wb1_addr = '0; bus2.wb1_data = '0;
        bus2.issue_en = 1'b0; bus2.issue_addr = '0;
        bus2.rd_addr = '0;
    endtask

    task automatic set_rd(logic [AW-1:0] a0, logic [AW-1:0] a1);
        bus.rd_addr = {a1, a0};
    endtask

    function automatic logic [AW-1:0] pick(logic [AW-1:0] hot);
        return ($urandom_range(2) == 0) ? hot : AW'($urandom_range(NUM_REGS - 1));
    endfunction

    // A shared "hot" address provokes collisions between lanes, issue and reads
    task automatic drive_random();
        logic [AW-1:0] hot = AW'($urandom_range(NUM_REGS - 1));
        bus.wb0_en     = ($urandom_range(99) < 40);
        bus.wb0_addr   = pick(hot);
        bus.wb0_data   = {$urandom, $urandom};
        bus.wb1_en     = ($urandom_range(99) < 40);
        bus.wb1_addr   = pick(hot);
        bus.wb1_data   = {$urandom, $urandom};
        bus.issue_en   = ($urandom_range(99) < 35);
        bus.issue_addr = pick(hot);
        set_rd(pick(hot), pick(hot));
    endtask

    // Called on the falling edge where reset was released; counts rising edges until ready
    task automatic wait_ready(string name, int exp_clocks, bit check2);
        int cyc = 0;
        int cyc2 = 0;
        forever begin
            drive_random();
            @(posedge clock);
            #1;
            cyc++;
            if (bus2.ready && cyc2 == 0) cyc2 = cyc;
            if (bus.ready || cyc >= 200) break;
            @(negedge clock);
        end
        chk(name, 64'(cyc), 64'(exp_clocks));
        if (check2) chk("ready2_clocks", 64'(cyc2), 64'(NUM_REGS2));
        @(negedge clock);
        idle();
    endtask

    initial begin
        reset_n = 1'b1;
        idle();
        idle2();
        #1 reset_n = 1'b0;
        chk_on = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        wait_ready("ready_clocks", 32, 1'b1);

        // Every entry zero, including those targeted by writes during the sweep
        for (int i = 0; i < NUM_REGS; i += 2) begin
            set_rd(AW'(i), AW'(i + 1));
            #3;
            chk("init_zero", 64'(bus.rd_data[0 +: XLEN]), 64'h0);
            chk("init_zero", 64'(bus.rd_data[XLEN +: XLEN]), 64'h0);
            @(negedge clock);
        end

        // Read-after-write latency
        bus.wb0_en = 1'b1; bus.wb0_addr = 5'd5; bus.wb0_data = 64'h1234;
        set_rd(5'd5, 5'd0);
        #3;
`ifdef REG_FILE_BYPASS_EN
        chk("raw_same_cycle", 64'(bus.rd_data[0 +: XLEN]), 64'h1234);
`else
        chk("raw_same_cycle", 64'(bus.rd_data[0 +: XLEN]), 64'h0);
`endif
        @(negedge clock); idle(); set_rd(5'd5, 5'd0);
        #3 chk("raw_next_cycle", 64'(bus.rd_data[0 +: XLEN]), 64'h1234);

        // Lane collision and x0 write
        @(negedge clock); idle();
        bus.wb0_en = 1'b1; bus.wb0_addr = 5'd7; bus.wb0_data = 64'hAA;
        bus.wb1_en = 1'b1; bus.wb1_addr = 5'd7; bus.wb1_data = 64'hBB;
        @(negedge clock); idle();
        bus.wb0_en = 1'b1; bus.wb0_addr = 5'd0; bus.wb0_data = 64'hFFFF;
        set_rd(5'd7, 5'd0);
        #3;
        chk("wb1_priority", 64'(bus.rd_data[0 +: XLEN]), 64'hBB);
        chk("x0_same_cycle", 64'(bus.rd_data[XLEN +: XLEN]), 64'h0);
        @(negedge clock); idle(); set_rd(5'd7, 5'd0);
        #3 chk("x0_after_write", 64'(bus.rd_data[XLEN +: XLEN]), 64'h0);

        // Scoreboard
        @(negedge clock); idle();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd9; set_rd(5'd9, 5'd9);
        #3 chk("busy_no_bypass", 64'(bus.rd_busy[0]), 64'h0);
        @(negedge clock); idle();
        bus.wb1_en = 1'b1; bus.wb1_addr = 5'd9; bus.wb1_data = 64'h99; set_rd(5'd9, 5'd9);
        #3 chk("busy_after_issue", 64'(bus.rd_busy[0]), 64'h1);
        @(negedge clock); idle();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
        bus.wb0_en = 1'b1; bus.wb0_addr = 5'd9; bus.wb0_data = 64'h55; set_rd(5'd9, 5'd9);
        #3 chk("busy_cleared_by_wb1", 64'(bus.rd_busy[1]), 64'h0);
        @(negedge clock); idle();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd0; set_rd(5'd9, 5'd9);
        #3;
        chk("busy_set_wins", 64'(bus.rd_busy[0]), 64'h1);
        chk("x9_data", 64'(bus.rd_data[XLEN +: XLEN]), 64'h55);
        @(negedge clock); idle(); set_rd(5'd0, 5'd9);
        #3 chk("x0_never_busy", 64'(bus.rd_busy[0]), 64'h0);

        // Four-port instance: distinct registers on each port
        @(negedge clock); idle();
        bus2.wb0_en = 1'b1; bus2.wb0_addr = 4'd1; bus2.wb0_data = 32'h1111_1111;
        bus2.wb1_en = 1'b1; bus2.wb1_addr = 4'd2; bus2.wb1_data = 32'h2222_2222;
        @(negedge clock);
        bus2.wb0_addr = 4'd3; bus2.wb0_data = 32'h3333_3333;
        bus2.wb1_addr = 4'd4; bus2.wb1_data = 32'h4444_4444;
        @(negedge clock); idle2();
        bus2.rd_addr = {4'd2, 4'd4, 4'd1, 4'd3};
        #3;
        chk("p4_port0", 64'(bus2.rd_data[0 +: XLEN2]), 64'h3333_3333);
        chk("p4_port1", 64'(bus2.rd_data[XLEN2 +: XLEN2]), 64'h1111_1111);
        chk("p4_port2", 64'(bus2.rd_data[2*XLEN2 +: XLEN2]), 64'h4444_4444);
        chk("p4_port3", 64'(bus2.rd_data[3*XLEN2 +: XLEN2]), 64'h2222_2222);
        @(negedge clock);
        bus2.rd_addr = {4'd1, 4'd2, 4'd15, 4'd0};
        #3;
        chk("p4_port0_x0", 64'(bus2.rd_data[0 +: XLEN2]), 64'h0);
        chk("p4_port1_x15", 64'(bus2.rd_data[XLEN2 +: XLEN2]), 64'h0);
        chk("p4_port2_x2", 64'(bus2.rd_data[2*XLEN2 +: XLEN2]), 64'h2222_2222);
        chk("p4_port3_x1", 64'(bus2.rd_data[3*XLEN2 +: XLEN2]), 64'h1111_1111);
        @(negedge clock); idle2();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive_random();
            @(negedge clock);
        end

        // Reset in the middle of the sweep restarts it
        idle();
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (10) begin
            drive_random();
            @(negedge clock);
        end
        reset_n = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        wait_ready("ready_after_restart", 32, 1'b0);
        for (int i = 0; i < 200; i++) begin
            drive_random();
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
